// File: rtl/xbar_ctrl_sender.sv
// xbar_ctrl_sender: initiator side of the crossbar control channel.
// Route requests are queued in a small FIFO, formatted into crossbar control
// words and issued one at a time over ctrl_val/ctrl_rdy. After each accepted
// word the sender idles for that request's hold count so in-flight packets
// drain before the route changes.
//
// state | meaning
// IDLE  | no word in flight; pops the FIFO head when one is queued
// SEND  | ctrl_msg presented with ctrl_val high until ctrl_rdy
// HOLD  | drain gap after a handshake, lasts exactly the latched hold count
module xbar_ctrl_sender #(
    parameter int BIT_WIDTH         = 32,
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int ADDRESS_BIT_WIDTH = 4,
    parameter int FIFO_DEPTH        = 4,
    parameter int HOLD_BITS         = 8,
    localparam int ISW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int OSW = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1,
    localparam int AW  = ADDRESS_BIT_WIDTH,
    localparam int PW  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        req_addr,
    input  logic [ISW-1:0]       req_in_sel,
    input  logic [OSW-1:0]       req_out_sel,
    input  logic [HOLD_BITS-1:0] req_hold,
    input  logic                 req_val,
    output logic                 req_rdy,
    output logic [BIT_WIDTH-1:0] ctrl_msg,
    output logic                 ctrl_val,
    input  logic                 ctrl_rdy,
    output logic [PW-1:0]        pending,
    output logic                 busy
);

    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW   = AW + ISW + OSW + HOLD_BITS;
    localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [PTRW-1:0]      wr_ptr, rd_ptr;
    logic [PW-1:0]        count;
    logic                 push, pop;

    logic [EW-1:0]        head;
    logic [AW-1:0]        head_addr;
    logic [ISW-1:0]       head_in_sel;
    logic [OSW-1:0]       head_out_sel;
    logic [HOLD_BITS-1:0] head_hold;

    logic [HOLD_BITS-1:0] hold_val;
    logic [HOLD_BITS-1:0] hold_cnt;

    // Address in the top bits, then the write flag, then input/output selects.
    function automatic logic [BIT_WIDTH-1:0] fmt_word(
        input logic [AW-1:0]  a,
        input logic [ISW-1:0] i,
        input logic [OSW-1:0] o
    );
        logic [BIT_WIDTH-1:0] w;
        w = '0;
        w[BIT_WIDTH-1 -: AW]            = a;
        w[BIT_WIDTH-AW-1]               = 1'b1;
        w[BIT_WIDTH-AW-2 -: ISW]        = i;
        w[BIT_WIDTH-AW-2-ISW -: OSW]    = o;
        return w;
    endfunction

    // No bypass: a full FIFO refuses a push even while it is being popped.
    assign req_rdy = (count < DEPTH_C);
    assign push    = req_val && req_rdy;
    assign pop     = (state == IDLE) && (count != '0);
    assign pending = count;

    assign head         = mem[rd_ptr];
    assign head_addr    = head[EW-1 -: AW];
    assign head_in_sel  = head[EW-AW-1 -: ISW];
    assign head_out_sel = head[EW-AW-ISW-1 -: OSW];
    assign head_hold    = head[HOLD_BITS-1:0];

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_addr, req_in_sel, req_out_sel, req_hold};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Word register and hold timer: load on pop, clear on handshake, count down in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_msg <= '0;
            hold_val <= '0;
            hold_cnt <= '0;
        end else begin
            if (pop) begin
                ctrl_msg <= fmt_word(head_addr, head_in_sel, head_out_sel);
                hold_val <= head_hold;
            end else if (state == SEND && ctrl_rdy) begin
                ctrl_msg <= '0;
                hold_cnt <= hold_val;
            end
            if (state == HOLD) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count != '0) state_nxt = SEND;
            SEND: if (ctrl_rdy) state_nxt = (hold_val != '0) ? HOLD : IDLE;
            HOLD: if (hold_cnt <= HOLD_BITS'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ctrl_val = (state == SEND);
        busy     = (state != IDLE) || (count != '0);
    end

endmodule

// File: tb/tb_xbar_ctrl_sender.sv
// Directed bench for xbar_ctrl_sender: a table of single-request format and
// latency vectors, plus sequences for hold timing, back-pressure, FIFO wrap
// and mid-operation reset.
module tb_xbar_ctrl_sender;

    logic        clk;
    logic        reset;
    logic [3:0]  req_addr;
    logic [0:0]  req_in_sel;
    logic [0:0]  req_out_sel;
    logic [7:0]  req_hold;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] ctrl_msg;
    logic        ctrl_val;
    logic        ctrl_rdy;
    logic [2:0]  pending;
    logic        busy;

    xbar_ctrl_sender dut (
        .clk         (clk),
        .reset       (reset),
        .req_addr    (req_addr),
        .req_in_sel  (req_in_sel),
        .req_out_sel (req_out_sel),
        .req_hold    (req_hold),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .ctrl_msg    (ctrl_msg),
        .ctrl_val    (ctrl_val),
        .ctrl_rdy    (ctrl_rdy),
        .pending     (pending),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic        in_sel;
        logic        out_sel;
        logic [7:0]  hold;
        logic [31:0] exp_msg;
    } vec_t;

    int nvec  = 0;
    int nmiss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [3:0] a, input logic i, input logic o);
        return {a, 1'b1, i, o, 25'd0};
    endfunction

    task automatic drive(input logic [3:0] a, input logic i, input logic o, input logic [7:0] h);
        req_addr    = a;
        req_in_sel  = i;
        req_out_sel = o;
        req_hold    = h;
        req_val     = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        vt [6];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic [31:0] held;
    logic [3:0]  ra [10];
    logic        ri [10];
    logic        ro [10];
    int          accepted;
    int          sent;
    int          maxp;

    initial begin
        vt[0] = '{addr: 4'h2, in_sel: 1'b1, out_sel: 1'b0, hold: 8'd0, exp_msg: 32'h2C00_0000};
        vt[1] = '{addr: 4'h0, in_sel: 1'b0, out_sel: 1'b0, hold: 8'd0, exp_msg: 32'h0800_0000};
        vt[2] = '{addr: 4'hF, in_sel: 1'b1, out_sel: 1'b1, hold: 8'd1, exp_msg: 32'hFE00_0000};
        vt[3] = '{addr: 4'h5, in_sel: 1'b0, out_sel: 1'b1, hold: 8'd0, exp_msg: 32'h5A00_0000};
        vt[4] = '{addr: 4'hA, in_sel: 1'b1, out_sel: 1'b0, hold: 8'd2, exp_msg: 32'hAC00_0000};
        vt[5] = '{addr: 4'h8, in_sel: 1'b0, out_sel: 1'b0, hold: 8'd4, exp_msg: 32'h8800_0000};

        reset = 1'b1; req_val = 1'b0; req_addr = '0; req_in_sel = '0;
        req_out_sel = '0; req_hold = '0; ctrl_rdy = 1'b1;
        step(); step();
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd1);
        check("rst_ctrl_val", 32'(ctrl_val), 32'd0);
        check("rst_ctrl_msg", ctrl_msg, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Single-request vectors: format, two-cycle latency, one-cycle pulse, hold gap.
        for (int k = 0; k < 6; k++) begin
            drive(vt[k].addr, vt[k].in_sel, vt[k].out_sel, vt[k].hold);
            step();
            req_val = 1'b0;
            check("vec_lat1_val", 32'(ctrl_val), 32'd0);
            check("vec_lat1_pending", 32'(pending), 32'd1);
            step();
            check("vec_val", 32'(ctrl_val), 32'd1);
            check("vec_msg", ctrl_msg, vt[k].exp_msg);
            step();
            check("vec_post_val", 32'(ctrl_val), 32'd0);
            check("vec_post_msg", ctrl_msg, 32'd0);
            check("vec_post_busy", 32'(busy), 32'(vt[k].hold != 8'd0));
            repeat (int'(vt[k].hold)) step();
            check("vec_idle_busy", 32'(busy), 32'd0);
            check("vec_idle_pending", 32'(pending), 32'd0);
        end

        // Hold timing: hold=3 gives three quiet cycles, next word five cycles after handshake.
        drive(4'h3, 1'b0, 1'b1, 8'd3);
        step();
        drive(4'h6, 1'b1, 1'b1, 8'd0);
        step();
        req_val = 1'b0;
        check("hold_first_val", 32'(ctrl_val), 32'd1);
        check("hold_first_msg", ctrl_msg, 32'h3A00_0000);
        for (int c = 0; c < 3; c++) begin
            step();
            check("hold_gap_val", 32'(ctrl_val), 32'd0);
            check("hold_gap_msg", ctrl_msg, 32'd0);
            check("hold_gap_busy", 32'(busy), 32'd1);
        end
        step();
        check("hold_idle_val", 32'(ctrl_val), 32'd0);
        step();
        check("hold_second_val", 32'(ctrl_val), 32'd1);
        check("hold_second_msg", ctrl_msg, 32'h6E00_0000);
        step();
        check("hold_done_val", 32'(ctrl_val), 32'd0);

        // Back-pressure: six pushes against a stalled channel, five fit.
        ctrl_rdy = 1'b0;
        accepted = 0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive(4'(i + 3), i[0], ~i[0], 8'd0);
            if (req_rdy) begin
                accepted++;
                exp_q.push_back(exp_word(4'(i + 3), i[0], ~i[0]));
            end
            step();
        end
        req_val = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_req_rdy", 32'(req_rdy), 32'd0);
        check("bp_pending", 32'(pending), 32'd4);
        check("bp_val", 32'(ctrl_val), 32'd1);
        held = ctrl_msg;
        check("bp_head_msg", held, exp_q[0]);
        repeat (3) step();
        check("bp_stable_msg", ctrl_msg, held);
        check("bp_stable_val", 32'(ctrl_val), 32'd1);

        // Release: pop cycle keeps req_rdy low, it rises the cycle after.
        got_q.delete();
        got_q.push_back(ctrl_msg);
        ctrl_rdy = 1'b1;
        step();
        check("rel_pop_req_rdy", 32'(req_rdy), 32'd0);
        check("rel_pop_pending", 32'(pending), 32'd4);
        step();
        check("rel_after_req_rdy", 32'(req_rdy), 32'd1);
        check("rel_after_pending", 32'(pending), 32'd3);
        if (ctrl_val) got_q.push_back(ctrl_msg);
        for (int c = 0; c < 40 && got_q.size() < 5; c++) begin
            step();
            if (ctrl_val) got_q.push_back(ctrl_msg);
        end
        step();
        check("rel_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check("rel_order_msg", got_q[i], exp_q[i]);
        end

        // Wrap-around: ten random-select requests streamed with hold=0.
        for (int i = 0; i < 10; i++) begin
            ra[i] = 4'($urandom_range(0, 15));
            ri[i] = 1'($urandom_range(0, 1));
            ro[i] = 1'($urandom_range(0, 1));
        end
        exp_q.delete();
        got_q.delete();
        sent = 0;
        maxp = 0;
        for (int c = 0; c < 200 && got_q.size() < 10; c++) begin
            if (ctrl_val) got_q.push_back(ctrl_msg);
            if (int'(pending) > maxp) maxp = int'(pending);
            if (sent < 10) begin
                drive(ra[sent], ri[sent], ro[sent], 8'd0);
                if (req_rdy) begin
                    exp_q.push_back(exp_word(ra[sent], ri[sent], ro[sent]));
                    sent++;
                end
            end else begin
                req_val = 1'b0;
            end
            step();
        end
        req_val = 1'b0;
        step();
        check("wrap_count", 32'(got_q.size()), 32'd10);
        check("wrap_max_pending_over", 32'(maxp > 4), 32'd0);
        check("wrap_pending_end", 32'(pending), 32'd0);
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            check("wrap_order_msg", got_q[i], exp_q[i]);
        end

        // Reset while in SEND with three queued requests.
        ctrl_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'(i + 1), 1'b1, 1'b0, 8'd5);
            step();
        end
        req_val = 1'b0;
        check("mrst_pre_val", 32'(ctrl_val), 32'd1);
        check("mrst_pre_pending", 32'(pending), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_val", 32'(ctrl_val), 32'd0);
        check("mrst_msg", ctrl_msg, 32'd0);
        check("mrst_pending", 32'(pending), 32'd0);
        check("mrst_req_rdy", 32'(req_rdy), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        ctrl_rdy = 1'b1;
        drive(4'h9, 1'b0, 1'b1, 8'd0);
        step();
        req_val = 1'b0;
        check("mrst_new_lat1_val", 32'(ctrl_val), 32'd0);
        step();
        check("mrst_new_val", 32'(ctrl_val), 32'd1);
        check("mrst_new_msg", ctrl_msg, 32'h9A00_0000);
        step();
        check("mrst_new_done_busy", 32'(busy), 32'd0);
        check("mrst_new_done_val", 32'(ctrl_val), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule

// File: doc/xbar_ctrl_sender.md
Name: xbar_ctrl_sender

Overview:
- Initiator side of the crossbar control channel.
- Accepts route-configuration requests (target block address, input select, output select, hold time) on a val/rdy port and buffers them in a small FIFO.
- Formats each request into a crossbar control word and issues it over the ctrl val/rdy interface, one at a time.
- After each accepted word, waits a per-request number of hold cycles before issuing the next, so in-flight packets drain before the route changes.

Parameters:
- BIT_WIDTH, 32, width of the control word.
- N_INPUTS, 2, crossbar inputs; ISW = $clog2(N_INPUTS).
- N_OUTPUTS, 2, crossbar outputs; OSW = $clog2(N_OUTPUTS).
- ADDRESS_BIT_WIDTH, 4, width of the block-address field (AW).
- FIFO_DEPTH, 4, request FIFO entries (power of 2, ≥2).
- HOLD_BITS, 8, width of the per-request hold counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_addr  in  AW  target block address.
- req_in_sel  in  ISW  crossbar input to route.
- req_out_sel  in  OSW  crossbar output to route to.
- req_hold  in  HOLD_BITS  idle cycles to insert after this word is accepted.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready (FIFO not full).
- ctrl_msg  out  BIT_WIDTH  formatted control word.
- ctrl_val  out  1  control word valid.
- ctrl_rdy  in  1  crossbar ready.
- pending  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- busy  out  1  high when state != IDLE or pending != 0.

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high. On reset:
  - FIFO is emptied; pending = 0, req_rdy = 1.
  - State goes to IDLE; ctrl_val = 0, ctrl_msg = 0, busy = 0, hold counter = 0.
  - Reset in any state discards the in-flight word and all queued requests. No partial handshake survives.
- Control word format (W = BIT_WIDTH):
  - [W-1 : W-AW] = req_addr.
  - Bit [W-AW-1] = 1 (write).
  - [W-AW-2 : W-AW-1-ISW] = req_in_sel.
  - [W-AW-2-ISW : W-AW-1-ISW-OSW] = req_out_sel.
  - All lower bits = 0.
  - Defaults: addr [31:28], write bit 27, in_sel bit 26, out_sel bit 25.
- Request FIFO:
  - req_rdy = (pending < FIFO_DEPTH). Enqueue when req_val && req_rdy.
  - No bypass: when full, req_rdy = 0 even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full leaves pending unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM, states IDLE / SEND / HOLD:
  - IDLE: ctrl_val = 0. If pending > 0, the head is popped, formatted into the ctrl_msg register, and its hold value is latched; next state SEND.
  - SEND: ctrl_val = 1. ctrl_msg is stable until ctrl_rdy; no change while ctrl_val && !ctrl_rdy. On ctrl_val && ctrl_rdy, go to HOLD with counter = hold if hold != 0, otherwise go to IDLE. ctrl_msg returns to 0 on leaving SEND.
  - HOLD: ctrl_val = 0. Counter decrements once per cycle; when it reaches 1 and decrements, next state is IDLE. HOLD lasts exactly hold cycles.
- Latency and throughput:
  - A request accepted at edge N produces ctrl_val = 1 in cycle N+2 (FIFO write, then IDLE load).
  - If a handshake completes in cycle H, the next ctrl_val is at H+hold+2 at the earliest.
  - With hold = 0, the minimum spacing between words is 2 cycles.
- Ordering: words are issued strictly in request order.
- Back-pressure: ctrl_rdy low for any duration stalls SEND; the FIFO continues to accept requests until full.

Test Plan:
- Single request: after reset, send addr=2, in=1, out=0, hold=0 → ctrl_msg=0x2C000000 with ctrl_val=1 exactly 2 cycles after acceptance; ctrl_rdy=1 gives a one-cycle valid pulse; busy then falls; pending ends at 0.
- Hold timing: two requests, the first with hold=3, ctrl_rdy tied high → second ctrl_val appears exactly 5 cycles after the first handshake cycle; the three HOLD cycles show ctrl_val=0 and ctrl_msg=0.
- Back-pressure and full FIFO: ctrl_rdy=0, push 6 requests → 5 accepted (4 in FIFO, 1 in SEND) and req_rdy=0; ctrl_msg is stable across the stall; releasing ctrl_rdy emits all 5 in order with correct fields.
- Wrap-around: stream 10 requests with random in/out selects and hold=0 → all 10 words appear in order with no loss or duplication; pending never exceeds 4.
- Reset mid-operation: assert reset while in SEND with 3 queued → next cycle ctrl_val=0, pending=0, req_rdy=1; a new request after reset is issued normally.
- Stall release in the push-equals-pop cycle: FIFO full, ctrl_rdy high → req_rdy stays 0 in the pop cycle and rises the cycle after.
